// File: rtl/flash_address_controller.sv
// Word-address generator in front of the flash reader: owns the current
// address, playback direction and play/pause state, and flags address wraps.
module flash_address_controller #(
  parameter int unsigned            ADDR_WIDTH = 23,
  parameter logic [ADDR_WIDTH-1:0]  START_ADDR = 23'h000000,
  parameter logic [ADDR_WIDTH-1:0]  END_ADDR   = 23'h07FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  address_inc,
  input  logic                  address_dec,
  input  logic                  address_rst,
  input  logic                  kbd_forward,
  input  logic                  kbd_backward,
  input  logic                  kbd_play,
  input  logic                  kbd_pause,
  input  logic                  kbd_restart,
  output logic [ADDR_WIDTH-1:0] flsh_address,
  output logic                  direction_fwd,
  output logic                  playing,
  output logic                  wrap_pulse
);

  localparam logic [ADDR_WIDTH-1:0] SPAN = END_ADDR - START_ADDR;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  dir_q, dir_d;
  logic                  play_q, play_d;
  logic                  wrap_q, wrap_d;

  logic [ADDR_WIDTH-1:0] reload;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  out_of_range;

  // Offset from START wraps to a huge value below START, so one compare
  // catches both sides of the window.
  assign reload       = dir_q ? START_ADDR : END_ADDR;
  assign offset       = addr_q - START_ADDR;
  assign out_of_range = (offset > SPAN);

  always_comb begin
    addr_d = addr_q;
    wrap_d = 1'b0;
    if (address_rst || kbd_restart) begin
      addr_d = reload;
    end else if (play_q && (address_inc ^ address_dec)) begin
      if (out_of_range) begin
        addr_d = reload;
        wrap_d = 1'b1;
      end else if (address_inc) begin
        if (addr_q == END_ADDR) begin
          addr_d = START_ADDR;
          wrap_d = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end else begin
        if (addr_q == START_ADDR) begin
          addr_d = END_ADDR;
          wrap_d = 1'b1;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    dir_d = dir_q;
    if (kbd_forward && !kbd_backward) begin
      dir_d = 1'b1;
    end else if (kbd_backward && !kbd_forward) begin
      dir_d = 1'b0;
    end
  end

  // Pause dominates a simultaneous play request.
  always_comb begin
    play_d = play_q;
    if (kbd_pause) begin
      play_d = 1'b0;
    end else if (kbd_play) begin
      play_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= START_ADDR;
      dir_q  <= 1'b1;
      play_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      dir_q  <= dir_d;
      play_q <= play_d;
      wrap_q <= wrap_d;
    end
  end

  assign flsh_address  = addr_q;
  assign direction_fwd = dir_q;
  assign playing       = play_q;
  assign wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_flash_address_controller.sv
// Directed bench for flash_address_controller with a reference model checked
// every cycle plus hand-computed spot expectations.
module tb_flash_address_controller;

  localparam int AW     = 23;
  localparam int ST     = 'h10;
  localparam int EN     = 'h13;
  localparam int SPAN_N = EN - ST + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic address_inc = 1'b0, address_dec = 1'b0, address_rst = 1'b0;
  logic kbd_forward = 1'b0, kbd_backward = 1'b0, kbd_play = 1'b0;
  logic kbd_pause = 1'b0, kbd_restart = 1'b0;
  logic [AW-1:0] flsh_address;
  logic direction_fwd, playing, wrap_pulse;

  int checks = 0;
  int errors = 0;

  flash_address_controller #(
    .ADDR_WIDTH(AW),
    .START_ADDR(23'h10),
    .END_ADDR  (23'h13)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .address_inc  (address_inc),
    .address_dec  (address_dec),
    .address_rst  (address_rst),
    .kbd_forward  (kbd_forward),
    .kbd_backward (kbd_backward),
    .kbd_play     (kbd_play),
    .kbd_pause    (kbd_pause),
    .kbd_restart  (kbd_restart),
    .flsh_address (flsh_address),
    .direction_fwd(direction_fwd),
    .playing      (playing),
    .wrap_pulse   (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: address kept as an offset-modulo counter within the window.
  int m_addr = ST;
  int m_dir = 1, m_play = 0, m_wrap = 0;
  logic m_valid = 1'b0;

  always @(posedge clk) begin
    int off;
    if (rst) begin
      m_addr  <= ST;
      m_dir   <= 1;
      m_play  <= 0;
      m_wrap  <= 0;
      m_valid <= 1'b1;
    end else begin
      m_wrap <= 0;
      if (address_rst || kbd_restart) begin
        m_addr <= (m_dir == 1) ? ST : EN;
      end else if (m_play == 1 && address_inc != address_dec) begin
        if (m_addr < ST || m_addr > EN) begin
          m_addr <= (m_dir == 1) ? ST : EN;
          m_wrap <= 1;
        end else if (address_inc) begin
          off = (m_addr - ST + 1) % SPAN_N;
          m_addr <= ST + off;
          m_wrap <= (off == 0) ? 1 : 0;
        end else begin
          off = (m_addr - ST + SPAN_N - 1) % SPAN_N;
          m_addr <= ST + off;
          m_wrap <= (m_addr == ST) ? 1 : 0;
        end
      end
      if (kbd_pause) m_play <= 0;
      else if (kbd_play) m_play <= 1;
      if (kbd_forward && !kbd_backward) m_dir <= 1;
      else if (kbd_backward && !kbd_forward) m_dir <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_addr", int'(flsh_address), m_addr);
      chk("model_dir", int'(direction_fwd), m_dir);
      chk("model_play", int'(playing), m_play);
      chk("model_wrap", int'(wrap_pulse), m_wrap);
    end
  end

  // Drive one cycle of inputs, held until the next call.
  task automatic cyc(input logic r, input logic inc, input logic dec, input logic arst,
                     input logic fwd, input logic bwd, input logic ply, input logic pse,
                     input logic rstrt);
    @(negedge clk);
    rst = r; address_inc = inc; address_dec = dec; address_rst = arst;
    kbd_forward = fwd; kbd_backward = bwd; kbd_play = ply; kbd_pause = pse;
    kbd_restart = rstrt;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Hand-computed expectation, sampled just after the edge that consumed the last cyc().
  task automatic lit(input string name, input int addr, input int dir, input int ply, input int wrp);
    @(posedge clk);
    #1;
    chk({name, "_addr"}, int'(flsh_address), addr);
    chk({name, "_dir"}, int'(direction_fwd), dir);
    chk({name, "_play"}, int'(playing), ply);
    chk({name, "_wrap"}, int'(wrap_pulse), wrp);
  endtask

  initial begin
    // Reset with noise on every other input
    for (int i = 0; i < 2; i++)
      cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    lit("reset", 'h10, 1, 0, 0);

    // Paused gating
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    lit("paused_inc", 'h10, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0); lit("play_on", 'h10, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); lit("inc1", 'h11, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); lit("inc2", 'h12, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); lit("inc3", 'h13, 1, 1, 0);

    // Forward wrap, pulse lasts one cycle
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); lit("fwd_wrap", 'h10, 1, 1, 1);
    idle();                         lit("fwd_wrap_end", 'h10, 1, 1, 0);

    // Backward
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0); lit("bwd_set", 'h10, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0); lit("bwd_wrap", 'h13, 0, 1, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0); lit("dec", 'h12, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0); lit("arst_bwd", 'h13, 0, 1, 0);

    // Simultaneous events
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0); lit("dec_to12", 'h12, 0, 1, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0); lit("inc_dec", 'h12, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0); lit("play_pause", 'h12, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0); lit("replay", 'h12, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 0); lit("fwd_bwd_hold", 'h12, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0); lit("fwd_set", 'h12, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1); lit("inc_restart", 'h10, 1, 1, 0);

    // Pause/resume, then reset mid-stream
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); lit("to12", 'h12, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); lit("paused_hold", 'h12, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); lit("resume", 'h13, 1, 1, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0); lit("mid_reset", 'h10, 1, 0, 0);

    // Random traffic against the model
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 11) == 0),
          1'($urandom_range(0, 15) == 0));
    idle();
    idle();
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_address_controller.md
Name: flash_address_controller

Overview:
- Word-address generator sitting directly upstream of the flash reader.
- Owns the current flash word address, playback direction and play/pause state.
- Applies the reader's address_inc / address_dec / address_rst pulses and the keyboard command pulses.
- Drives flsh_address to the flash Avalon master and reports direction/playing status back to the reader.

Parameters:
- ADDR_WIDTH, 23: width of flsh_address (word address).
- START_ADDR, 23'h000000: first word of the audio region.
- END_ADDR, 23'h07FFFF: last word of the audio region (inclusive); must satisfy START_ADDR < END_ADDR.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- address_inc  in  1  one-cycle pulse from reader: address +1
- address_dec  in  1  one-cycle pulse from reader: address -1
- address_rst  in  1  one-cycle pulse from reader: reload direction-dependent start address
- kbd_forward  in  1  pulse: set direction forward
- kbd_backward  in  1  pulse: set direction backward
- kbd_play  in  1  pulse: set playing
- kbd_pause  in  1  pulse: clear playing
- kbd_restart  in  1  pulse: reload direction-dependent start address
- flsh_address  out  ADDR_WIDTH  current word address to flash
- direction_fwd  out  1  1 = forward, 0 = backward
- playing  out  1  1 = playback enabled; reader gates startsamplenow with this
- wrap_pulse  out  1  one-cycle pulse when the address wraps

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state changes on posedge clk; all outputs are registered.
- Reset values: flsh_address = START_ADDR, direction_fwd = 1, playing = 0, wrap_pulse = 0.
- Reload value R = START_ADDR when direction_fwd = 1, END_ADDR when direction_fwd = 0. R uses the direction register value *before* the edge.
- Address update, priority high to low, evaluated each edge:
  1. rst
  2. address_rst or kbd_restart → flsh_address = R, no wrap_pulse
  3. playing = 0 → inc/dec ignored; address holds
  4. address_inc and address_dec both high → no change
  5. address_inc → END_ADDR wraps to START_ADDR with wrap_pulse = 1; otherwise +1
  6. address_dec → START_ADDR wraps to END_ADDR with wrap_pulse = 1; otherwise -1
- Latency: a pulse sampled at edge N is visible on flsh_address after edge N (one-cycle registered latency).
- wrap_pulse is high for exactly the cycle following the wrapping edge, and 0 in every other cycle.
- Direction register:
  - kbd_forward → 1; kbd_backward → 0; both high → hold.
  - A direction change does not alter the address. It affects only reload value R and the reader's choice of inc/dec, from the next cycle on.
- Playing register:
  - kbd_play → 1; kbd_pause → 0; both high → pause wins (0).
  - Independent of the address path. Pausing mid-word freezes the address; play resumes from the same address.
- Out-of-range safety: if flsh_address is ever outside [START_ADDR, END_ADDR] at an inc/dec, the next value is R with wrap_pulse = 1. This guarantees recovery.
- Arithmetic: unsigned, ADDR_WIDTH bits; no carry/borrow escapes the range logic.
- Reset mid-operation returns all outputs to reset values on the same edge, regardless of other inputs.

Test Plan:
- All tests use START_ADDR = 23'h10, END_ADDR = 23'h13.
- Reset: hold rst 2 cycles with random pulses on other inputs → flsh_address = 0x10, direction_fwd = 1, playing = 0, wrap_pulse = 0.
- Paused gating: with playing = 0, pulse address_inc ×3 → address stays 0x10. Then kbd_play, address_inc ×3 → 0x11, 0x12, 0x13, each one cycle after its pulse.
- Forward wrap: at 0x13, address_inc → 0x10, with wrap_pulse high exactly one cycle.
- Backward: kbd_backward, then address_dec from 0x10 → 0x13 with wrap_pulse. Next address_dec → 0x12. Then address_rst → 0x13 (END, direction backward).
- Simultaneous events:
  - address_inc and address_dec same cycle at 0x12 → holds 0x12.
  - kbd_play and kbd_pause same cycle → playing = 0.
  - address_inc and kbd_restart same cycle (forward) → 0x10, no wrap_pulse.
- Pause/resume, then mid-stream reset: at 0x12, kbd_pause, address_inc ×2 → 0x12. kbd_play, address_inc → 0x13. Assert rst in the same cycle as address_inc → 0x10, playing = 0.
